// File: rtl/ans_cmd_sequencer_if.sv
// Bundles the host command, encoder and host output-stream signals of the ANS command sequencer.
// The slave modport is the sequencer's view; master is the surrounding host/encoder environment.
interface ans_cmd_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 4
) ();

  logic [DATA_WIDTH-1:0] host_data;
  logic [1:0]            host_cmd;
  logic                  host_vld;
  logic                  host_rdy;

  logic [DATA_WIDTH-1:0] enc_in;
  logic                  enc_in_vld;
  logic                  enc_in_rdy;

  logic                  tbl_we;
  logic [1:0]            tbl_addr;
  logic [DATA_WIDTH-1:0] tbl_data;

  logic                  enc_flush_req;
  logic                  enc_flush_ack;
  logic                  enc_clear;

  logic [DATA_WIDTH-1:0] enc_out;
  logic                  enc_out_vld;
  logic                  enc_out_rdy;

  logic [DATA_WIDTH-1:0] out;
  logic                  out_vld;
  logic                  out_rdy;

  logic [7:0]            out_cnt;
  logic                  err;

  modport slave (
    input  host_data, host_cmd, host_vld, enc_in_rdy, enc_flush_ack,
           enc_out, enc_out_vld, out_rdy,
    output host_rdy, enc_in, enc_in_vld, tbl_we, tbl_addr, tbl_data,
           enc_flush_req, enc_clear, enc_out_rdy, out, out_vld, out_cnt, err
  );

  modport master (
    output host_data, host_cmd, host_vld, enc_in_rdy, enc_flush_ack,
           enc_out, enc_out_vld, out_rdy,
    input  host_rdy, enc_in, enc_in_vld, tbl_we, tbl_addr, tbl_data,
           enc_flush_req, enc_clear, enc_out_rdy, out, out_vld, out_cnt, err
  );

endinterface

// File: rtl/ans_cmd_sequencer.sv
// Decodes host nibble commands into ANS encoder symbol, table-load, flush and clear operations,
// and passes the encoder output stream back to the host while counting emitted nibbles.
module ans_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned NSYM       = 4
) (
  input  logic                clk,
  input  logic                rst,
  ans_cmd_sequencer_if.slave  bus
);

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] CMD_SYM   = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_FLUSH = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_DATA = 3'd1,
    S_SYM       = 3'd2,
    S_FLUSH     = 3'd3,
    S_CLEAR     = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] enc_in_q,   enc_in_d;
  logic                  tbl_we_q,   tbl_we_d;
  logic [ADDR_W-1:0]     tbl_addr_q, tbl_addr_d;
  logic [DATA_WIDTH-1:0] tbl_data_q, tbl_data_d;
  logic [NSYM-1:0]       loaded_q,   loaded_d;
  logic                  err_q,      err_d;
  logic [CNT_W-1:0]      out_cnt_q,  out_cnt_d;

  logic sym_ok_c;
  logic xfer_c;

  // A symbol is legal only if it is in range and its frequency entry has been written
  assign sym_ok_c = (32'(bus.host_data) < NSYM) && loaded_q[bus.host_data[ADDR_W-1:0]];
  assign xfer_c   = bus.enc_out_vld & bus.out_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.host_vld) begin
          unique case (bus.host_cmd)
            CMD_SYM:   if (sym_ok_c) state_d = S_SYM;
            CMD_LOAD:  state_d = S_LOAD_DATA;
            CMD_FLUSH: state_d = S_FLUSH;
            CMD_CLEAR: state_d = S_CLEAR;
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD_DATA: if (bus.host_vld)      state_d = S_IDLE;
      S_SYM:       if (bus.enc_in_rdy)    state_d = S_IDLE;
      S_FLUSH:     if (bus.enc_flush_ack) state_d = S_IDLE;
      S_CLEAR:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from the state register
  always_comb begin
    bus.host_rdy      = 1'b0;
    bus.enc_in_vld    = 1'b0;
    bus.enc_flush_req = 1'b0;
    bus.enc_clear     = 1'b0;
    unique case (state_q)
      S_IDLE:      bus.host_rdy      = 1'b1;
      S_LOAD_DATA: bus.host_rdy      = 1'b1;
      S_SYM:       bus.enc_in_vld    = 1'b1;
      S_FLUSH:     bus.enc_flush_req = 1'b1;
      S_CLEAR:     bus.enc_clear     = 1'b1;
      default:     bus.host_rdy      = 1'b0;
    endcase
  end

  // Datapath next values: symbol latch, table write port, loaded map, error flag, nibble count
  always_comb begin
    enc_in_d   = enc_in_q;
    tbl_we_d   = 1'b0;
    tbl_addr_d = tbl_addr_q;
    tbl_data_d = tbl_data_q;
    loaded_d   = loaded_q;
    err_d      = err_q;
    out_cnt_d  = out_cnt_q;

    if (state_q == S_CLEAR) begin
      err_d     = 1'b0;
      out_cnt_d = '0;
    end else if (xfer_c && (out_cnt_q != {CNT_W{1'b1}})) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end

    if ((state_q == S_IDLE) && bus.host_vld) begin
      if (bus.host_cmd == CMD_SYM) begin
        if (sym_ok_c) begin
          enc_in_d = bus.host_data;
        end else begin
          err_d = 1'b1;
        end
      end else if (bus.host_cmd == CMD_LOAD) begin
        tbl_addr_d = bus.host_data[ADDR_W-1:0];
      end
    end

    // A zero frequency would make the symbol unencodable, so it is rejected
    if ((state_q == S_LOAD_DATA) && bus.host_vld) begin
      tbl_data_d = bus.host_data;
      if (bus.host_data != '0) begin
        tbl_we_d             = 1'b1;
        loaded_d[tbl_addr_q] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_in_q   <= '0;
      tbl_we_q   <= 1'b0;
      tbl_addr_q <= '0;
      tbl_data_q <= '0;
      loaded_q   <= '0;
      err_q      <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      enc_in_q   <= enc_in_d;
      tbl_we_q   <= tbl_we_d;
      tbl_addr_q <= tbl_addr_d;
      tbl_data_q <= tbl_data_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign bus.enc_in   = enc_in_q;
  assign bus.tbl_we   = tbl_we_q;
  assign bus.tbl_addr = tbl_addr_q;
  assign bus.tbl_data = tbl_data_q;
  assign bus.err      = err_q;
  assign bus.out_cnt  = out_cnt_q;

  // Output stream is a zero-latency pass-through
  assign bus.out         = bus.enc_out;
  assign bus.out_vld     = bus.enc_out_vld;
  assign bus.enc_out_rdy = bus.out_rdy;

endmodule

// File: tb/tb_ans_cmd_sequencer.sv
// Bench for ans_cmd_sequencer: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against an operation-level model of the sequencer.
module tb_ans_cmd_sequencer;

  localparam int unsigned DW   = 4;
  localparam int unsigned NSYM = 4;

  localparam int MD_IDLE  = 0;
  localparam int MD_ADDR  = 1;
  localparam int MD_SYM   = 2;
  localparam int MD_FLUSH = 3;
  localparam int MD_CLEAR = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ans_cmd_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  ans_cmd_sequencer #(.DATA_WIDTH(DW), .NSYM(NSYM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which operation is pending, plus the architectural registers it implies
  bit m_ok = 1'b0;
  int m_mode;
  bit m_loaded [NSYM];
  int m_cnt, m_err, m_enc_in, m_taddr, m_tdata, m_twe;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_compare();
    if (!m_ok) return;
    chk("m.host_rdy",   int'(bus.host_rdy),      int'(m_mode == MD_IDLE || m_mode == MD_ADDR));
    chk("m.enc_in_vld", int'(bus.enc_in_vld),    int'(m_mode == MD_SYM));
    chk("m.enc_in",     int'(bus.enc_in),        m_enc_in);
    chk("m.tbl_we",     int'(bus.tbl_we),        m_twe);
    if (m_twe != 0) begin
      chk("m.tbl_addr", int'(bus.tbl_addr),      m_taddr);
      chk("m.tbl_data", int'(bus.tbl_data),      m_tdata);
    end
    chk("m.flush_req",  int'(bus.enc_flush_req), int'(m_mode == MD_FLUSH));
    chk("m.enc_clear",  int'(bus.enc_clear),     int'(m_mode == MD_CLEAR));
    chk("m.out_cnt",    int'(bus.out_cnt),       m_cnt);
    chk("m.err",        int'(bus.err),           m_err);
    chk("m.out",        int'(bus.out),           int'(bus.enc_out));
    chk("m.out_vld",    int'(bus.out_vld),       int'(bus.enc_out_vld));
    chk("m.enc_out_rdy", int'(bus.enc_out_rdy),  int'(bus.out_rdy));
  endtask

  // Advance the model by one clock using the inputs that the next rising edge will sample
  task automatic model_advance();
    int d;
    if (rst) begin
      m_mode = MD_IDLE;
      foreach (m_loaded[i]) m_loaded[i] = 1'b0;
      m_cnt = 0; m_err = 0; m_enc_in = 0; m_taddr = 0; m_tdata = 0; m_twe = 0;
      m_ok = 1'b1;
      return;
    end
    if (!m_ok) return;
    m_twe = 0;
    if (m_mode == MD_CLEAR) begin
      m_cnt = 0;
      m_err = 0;
    end else if (bus.enc_out_vld && bus.out_rdy) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    d = int'(bus.host_data);
    case (m_mode)
      MD_IDLE: if (bus.host_vld) begin
        case (int'(bus.host_cmd))
          0: if (d < NSYM && m_loaded[d]) begin m_enc_in = d; m_mode = MD_SYM; end
             else m_err = 1;
          1: begin m_taddr = d % 4; m_mode = MD_ADDR; end
          2: m_mode = MD_FLUSH;
          default: m_mode = MD_CLEAR;
        endcase
      end
      MD_ADDR: if (bus.host_vld) begin
        if (d != 0) begin m_twe = 1; m_tdata = d; m_loaded[m_taddr] = 1'b1; end
        else m_err = 1;
        m_mode = MD_IDLE;
      end
      MD_SYM:   if (bus.enc_in_rdy)    m_mode = MD_IDLE;
      MD_FLUSH: if (bus.enc_flush_ack) m_mode = MD_IDLE;
      default:  m_mode = MD_IDLE;
    endcase
  endtask

  initial begin
    int hi;
    int k;
    rst = 1'b1;
    bus.host_data = '0; bus.host_cmd = '0; bus.host_vld = 1'b0;
    bus.enc_in_rdy = 1'b0; bus.enc_flush_ack = 1'b0;
    bus.enc_out = '0; bus.enc_out_vld = 1'b0; bus.out_rdy = 1'b0;

    fork
      forever begin
        @(negedge clk);
        model_compare();
        model_advance();
      end
    join_none

    // Reset state
    tick(); tick();
    chk("rst.host_rdy", int'(bus.host_rdy), 1);
    chk("rst.enc_in_vld", int'(bus.enc_in_vld), 0);
    chk("rst.tbl_we", int'(bus.tbl_we), 0);
    chk("rst.flush_req", int'(bus.enc_flush_req), 0);
    chk("rst.enc_clear", int'(bus.enc_clear), 0);
    chk("rst.out_cnt", int'(bus.out_cnt), 0);
    chk("rst.err", int'(bus.err), 0);
    chk("rst.enc_in", int'(bus.enc_in), 0);
    rst = 1'b0;

    // Load address 2 with frequency 5
    bus.host_vld = 1'b1; bus.host_cmd = 2'b01; bus.host_data = 4'd2;
    tick();
    chk("load.rdy_in_data", int'(bus.host_rdy), 1);
    bus.host_cmd = 2'b00; bus.host_data = 4'd5;
    tick();
    chk("load.tbl_we", int'(bus.tbl_we), 1);
    chk("load.tbl_addr", int'(bus.tbl_addr), 2);
    chk("load.tbl_data", int'(bus.tbl_data), 5);
    chk("load.host_rdy", int'(bus.host_rdy), 1);
    bus.host_vld = 1'b0;
    tick();
    chk("load.we_once", int'(bus.tbl_we), 0);

    // Symbol 2 with the encoder stalling three cycles
    bus.host_vld = 1'b1; bus.host_cmd = 2'b00; bus.host_data = 4'd2; bus.enc_in_rdy = 1'b0;
    tick();
    bus.host_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sym.enc_in_vld", int'(bus.enc_in_vld), 1);
      chk("sym.enc_in", int'(bus.enc_in), 2);
      chk("sym.host_rdy", int'(bus.host_rdy), 0);
      if (i == 3) bus.enc_in_rdy = 1'b1;
      tick();
    end
    chk("sym.vld_drop", int'(bus.enc_in_vld), 0);
    chk("sym.rdy_back", int'(bus.host_rdy), 1);
    bus.enc_in_rdy = 1'b0;

    // Error drops: unloaded symbol, out-of-range symbol, zero frequency
    bus.host_vld = 1'b1; bus.host_cmd = 2'b00; bus.host_data = 4'd3;
    tick();
    chk("err.unloaded", int'(bus.err), 1);
    chk("err.unloaded_vld", int'(bus.enc_in_vld), 0);
    chk("err.zero_bubble", int'(bus.host_rdy), 1);
    bus.host_data = 4'd9;
    tick();
    chk("err.range_vld", int'(bus.enc_in_vld), 0);
    bus.host_cmd = 2'b01; bus.host_data = 4'd1;
    tick();
    bus.host_cmd = 2'b00; bus.host_data = 4'd0;
    tick();
    chk("err.zero_freq_we", int'(bus.tbl_we), 0);
    chk("err.zero_freq", int'(bus.err), 1);
    bus.host_cmd = 2'b11;
    tick();
    bus.host_vld = 1'b0;
    chk("clr.pulse", int'(bus.enc_clear), 1);
    chk("clr.host_rdy", int'(bus.host_rdy), 0);
    tick();
    chk("clr.pulse_end", int'(bus.enc_clear), 0);
    chk("clr.err", int'(bus.err), 0);

    // Flush acknowledged on its sixth high cycle
    bus.host_vld = 1'b1; bus.host_cmd = 2'b10;
    tick();
    bus.host_vld = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.enc_flush_req) hi++;
      bus.enc_flush_ack = (bus.enc_flush_req && hi == 6);
      tick();
    end
    bus.enc_flush_ack = 1'b0;
    chk("flush.req_cycles", hi, 6);
    chk("flush.idle", int'(bus.host_rdy), 1);

    // 300 transfers with out_rdy toggling saturate the count
    for (int i = 0; i < 600; i++) begin
      bus.enc_out_vld = 1'b1;
      bus.out_rdy = (i % 2) == 1;
      bus.enc_out = DW'(i);
      tick();
    end
    chk("cnt.saturate", int'(bus.out_cnt), 255);
    bus.out_rdy = 1'b1;
    bus.host_vld = 1'b1; bus.host_cmd = 2'b11;
    tick();
    bus.host_vld = 1'b0;
    tick();
    chk("cnt.clear_wins", int'(bus.out_cnt), 0);
    bus.enc_out_vld = 1'b0; bus.out_rdy = 1'b0;

    // Reset in the middle of a symbol handshake discards the loaded map
    bus.host_vld = 1'b1; bus.host_cmd = 2'b00; bus.host_data = 4'd2;
    tick();
    bus.host_vld = 1'b0;
    chk("rsym.vld", int'(bus.enc_in_vld), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsym.vld_after", int'(bus.enc_in_vld), 0);
    chk("rsym.host_rdy", int'(bus.host_rdy), 1);
    bus.host_vld = 1'b1; bus.host_cmd = 2'b00; bus.host_data = 4'd2;
    tick();
    chk("rsym.unloaded_err", int'(bus.err), 1);
    chk("rsym.unloaded_vld", int'(bus.enc_in_vld), 0);

    // Reset during the frequency beat of a load
    bus.host_cmd = 2'b01; bus.host_data = 4'd1;
    tick();
    bus.host_cmd = 2'b00; bus.host_data = 4'd7; rst = 1'b1;
    tick();
    chk("rload.we", int'(bus.tbl_we), 0);
    chk("rload.err", int'(bus.err), 0);
    rst = 1'b0; bus.host_vld = 1'b0;
    tick();
    chk("rload.we_after", int'(bus.tbl_we), 0);
    bus.host_vld = 1'b1; bus.host_cmd = 2'b00; bus.host_data = 4'd1;
    tick();
    chk("rload.discarded", int'(bus.err), 1);
    bus.host_vld = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.host_vld = ($urandom_range(0, 2) != 0);
      k = int'($urandom_range(0, 19));
      bus.host_cmd = (k < 8) ? 2'b00 : (k < 14) ? 2'b01 : (k < 18) ? 2'b10 : 2'b11;
      bus.host_data = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15))
                                                  : DW'($urandom_range(0, 4));
      bus.enc_in_rdy    = ($urandom_range(0, 2) == 0);
      bus.enc_flush_ack = ($urandom_range(0, 3) == 0);
      bus.enc_out_vld   = 1'($urandom_range(0, 1));
      bus.out_rdy       = 1'($urandom_range(0, 1));
      bus.enc_out       = DW'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; bus.host_vld = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ans_cmd_sequencer.md
# ans_cmd_sequencer

Command sequencer between the 4-bit host nibble port and the ANS encoder core. It decodes the 2-bit host command into four operations: encode symbol, load frequency-table entry, flush encoder state, and clear. It drives the encoder's symbol handshake, table write port, flush request and clear strobe. It also passes the encoder's output nibble stream back to the host and counts emitted nibbles.

## Interface
- `DATA_WIDTH`, 4, host/encoder nibble width
- `NSYM`, 4, frequency-table entries; legal symbols 0..NSYM-1

- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `host_data`  in  DATA_WIDTH  command payload nibble
- `host_cmd`  in  2  00 symbol, 01 load, 10 flush, 11 clear
- `host_vld` in 1 / `host_rdy` out 1  host command handshake
- `enc_in` out DATA_WIDTH, `enc_in_vld` out 1, `enc_in_rdy` in 1  symbol handshake to encoder
- `tbl_we` out 1, `tbl_addr` out 2, `tbl_data` out DATA_WIDTH  frequency-table write port (one-cycle strobe)
- `enc_flush_req` out 1 / `enc_flush_ack` in 1  flush handshake
- `enc_clear`  out  1  one-cycle encoder state clear
- `enc_out` in DATA_WIDTH, `enc_out_vld` in 1, `enc_out_rdy` out 1  encoder output stream
- `out` out DATA_WIDTH, `out_vld` out 1, `out_rdy` in 1  host output stream
- `out_cnt`  out  8  emitted-nibble count, saturating
- `err`  out  1  sticky protocol error

## Operation
- States: IDLE, LOAD_DATA, SYM, FLUSH, CLEAR.
- A beat is accepted when `host_vld & host_rdy`. `host_rdy` = 1 only in IDLE and LOAD_DATA.
- IDLE, cmd 00:
  - sym = `host_data`. If sym >= NSYM or `loaded[sym]`==0: drop it, set `err`, stay IDLE.
  - Otherwise latch sym into `enc_in` and go to SYM.
- IDLE, cmd 01: latch `host_data[1:0]` as address, go to LOAD_DATA.
- LOAD_DATA: next accepted beat (its cmd ignored) is the frequency.
  - Nonzero: one-cycle `tbl_we` with latched address and data, set `loaded[addr]`.
  - Zero: no write, set `err`.
  - Either case: return to IDLE.
- IDLE, cmd 10: go to FLUSH.
- IDLE, cmd 11: go to CLEAR.
- SYM: `enc_in_vld`=1, `enc_in` stable. When `enc_in_rdy` is sampled 1, go to IDLE.
- FLUSH: `enc_flush_req`=1. When `enc_flush_ack` is sampled 1, go to IDLE.
- CLEAR: `enc_clear`=1 for exactly this cycle; `err`<=0, `out_cnt`<=0; go to IDLE. `loaded[]` is kept.
- Output path is combinational pass-through: `out`=`enc_out`, `out_vld`=`enc_out_vld`, `enc_out_rdy`=`out_rdy`.
- `out_cnt` increments on each `out_vld & out_rdy` and saturates at 255. A clear in the same cycle wins (result 0).
- `loaded[]` (NSYM bits) is cleared only by `rst`.

## Timing
- Reset values:
  - State IDLE.
  - `host_rdy`=1.
  - `enc_in_vld`, `tbl_we`, `enc_flush_req`, `enc_clear` = 0.
  - `enc_in`, `tbl_addr`, `tbl_data` = 0.
  - `out_cnt`=0, `err`=0, `loaded`=0.
  - Pass-through outputs follow their inputs.
- Symbol accepted in cycle N: `enc_in_vld`=1 from N+1. If `enc_in_rdy`=1 at N+1, `host_rdy`=1 at N+2. Peak rate is 1 symbol per 2 cycles.
- Load: address beat at N, data beat at M>N; `tbl_we`=1 in cycle M+1 only; `host_rdy`=1 at M+1.
- Flush accepted at N: `enc_flush_req`=1 from N+1 through the cycle `enc_flush_ack` is sampled; low the next cycle.
- `enc_in_vld` and `enc_flush_req` must not drop before their rdy/ack. `enc_in` must not change while `enc_in_vld`=1.
- Error drop: `err`=1 from N+1; `host_rdy` stays 1 (zero-bubble).
- `rst` mid-SYM/FLUSH/LOAD_DATA: all outputs take reset values next cycle; the pending op is abandoned and any half-load is discarded.

## Test plan
- Reset with all inputs 0 -> `host_rdy`=1, all strobes 0, `out_cnt`=0, `err`=0.
- Load addr 2, freq 5, then symbol 2 with `enc_in_rdy` stalled 3 cycles -> `tbl_we`=1 one cycle (`tbl_addr`=2, `tbl_data`=5). `enc_in`=2 with `enc_in_vld` held 4 cycles. `host_rdy`=0 throughout.
- Symbol 3 unloaded, symbol 9, and load of freq 0 -> `err`=1, no `enc_in_vld`, no `tbl_we`. A following clear -> `enc_clear` pulse, `err`=0.
- Flush with ack after 5 cycles -> `enc_flush_req` high exactly 6 cycles, then IDLE.
- Stream 300 output nibbles with `out_rdy` toggling -> `out_cnt` saturates at 255. Clear coincident with a transfer -> `out_cnt`=0.
- Assert `rst` during SYM and during LOAD_DATA -> `enc_in_vld`=0, `loaded`=0, no `tbl_we` next cycle.
